// File: rtl/rv32i_types_pkg.sv
// Shared RV32I fetch-path types: word type, fetch FSM state encoding,
// bubble encoding and the PC increment helper.
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        IDLE   = 2'd2
    } fetch_state_t;

    localparam word_t RV32_NOP      = 32'h0000_0013;
    localparam word_t RV32_RESET_PC = 32'h0000_0200;

    // Sequential PC step; wraps modulo 2^32.
    function automatic word_t pc_plus4(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/tspp_ifex_latch.sv
// IF/EX pipeline latch. Priority: flush > stall > load > bubble.
// A flush or bubble keeps the pc/pc4 fields of the last loaded instruction.
module tspp_ifex_latch
    import rv32i_types_pkg::*;
#(
    parameter word_t NOP_INSTR = RV32_NOP
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        flush,
    input  logic        stall,
    input  logic        load,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    input  logic        load_fault,
    output logic        ifex_valid,
    output logic [31:0] ifex_instr,
    output logic [31:0] ifex_pc,
    output logic [31:0] ifex_pc4,
    output logic        ifex_fault
);

    // Latch update with flush/stall/load/bubble priority.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ifex_valid <= 1'b0;
            ifex_instr <= NOP_INSTR;
            ifex_pc    <= '0;
            ifex_pc4   <= '0;
            ifex_fault <= 1'b0;
        end else if (flush) begin
            ifex_valid <= 1'b0;
            ifex_instr <= NOP_INSTR;
            ifex_fault <= 1'b0;
        end else if (stall) begin
            ifex_valid <= ifex_valid;
        end else if (load) begin
            ifex_valid <= 1'b1;
            ifex_instr <= load_instr;
            ifex_pc    <= load_pc;
            ifex_pc4   <= pc_plus4(load_pc);
            ifex_fault <= load_fault;
        end else begin
            // A bubble never carries a fault.
            ifex_valid <= 1'b0;
            ifex_instr <= NOP_INSTR;
            ifex_fault <= 1'b0;
        end
    end

endmodule

// File: rtl/tspp_fetch_stage.sv
// Fetch stage: owns the PC, issues instruction-memory reads, squashes
// in-flight reads made stale by a redirect or halt, feeds the IF/EX latch.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned PC raises ifex_fault
// instead of issuing a read; without it the PC low bits are forced to 0.
//
//   state  | meaning
//   FETCH  | reading imem at pc; completion loads the IF/EX latch
//   SQUASH | finishing a stale read at squash_addr; data discarded
//   IDLE   | halted, no requests until reset
module tspp_fetch_stage
    import rv32i_types_pkg::*;
#(
    parameter word_t RESET_PC  = RV32_RESET_PC,
    parameter word_t NOP_INSTR = RV32_NOP
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pc_en,
    input  logic        npc_sel,
    input  logic        if_ex_stall,
    input  logic        if_ex_flush,
    input  logic        halt,
    input  logic [31:0] brj_addr,
    input  logic        imem_busy,
    input  logic [31:0] imem_rdata,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    output logic        iren,
    output logic        i_ram_busy,
    output logic        ifex_valid,
    output logic [31:0] ifex_instr,
    output logic [31:0] ifex_pc,
    output logic [31:0] ifex_pc4,
    output logic        ifex_fault
);

    fetch_state_t state, state_nx;
    word_t        pc, pc_target, pc_load, squash_addr;
    logic         halted_r, halt_seen, misaligned, fetch_done, req_busy;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
    assign pc_load    = pc_target;
`else
    assign misaligned = 1'b0;
    assign pc_load    = {pc_target[31:2], 2'b00};
`endif

    assign pc_target = npc_sel ? brj_addr : pc_plus4(pc);
    // A halt arriving in the same cycle a squash drains must still stop us.
    assign halt_seen = halted_r | halt;

    // Next-state and memory request outputs.
    always_comb begin
        state_nx   = state;
        imem_ren   = 1'b0;
        imem_addr  = pc;
        fetch_done = 1'b0;
        req_busy   = 1'b0;
        case (state)
            FETCH: begin
                imem_ren   = ~misaligned;
                fetch_done = misaligned | ~imem_busy;
                req_busy   = ~fetch_done;
                if (((pc_en & npc_sel) | halt) & req_busy)
                    state_nx = SQUASH;
                else if (halt)
                    state_nx = IDLE;
            end
            SQUASH: begin
                imem_ren  = 1'b1;
                imem_addr = squash_addr;
                if (!imem_busy)
                    state_nx = halt_seen ? IDLE : FETCH;
            end
            IDLE: begin
                state_nx = IDLE;
            end
            default: state_nx = FETCH;
        endcase
    end

    assign iren       = imem_ren;
    assign i_ram_busy = imem_busy | (state != FETCH);

    // State, PC, squash address and sticky halt registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            squash_addr <= '0;
            halted_r    <= 1'b0;
        end else begin
            state <= state_nx;
            if (pc_en)
                pc <= pc_load;
            if ((state == FETCH) && (state_nx == SQUASH))
                squash_addr <= pc;
            if (halt)
                halted_r <= 1'b1;
        end
    end

    tspp_ifex_latch #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifex_latch (
        .CLK        (CLK),
        .nRST       (nRST),
        .flush      (if_ex_flush),
        .stall      (if_ex_stall),
        .load       ((state == FETCH) & fetch_done),
        .load_instr (misaligned ? NOP_INSTR : imem_rdata),
        .load_pc    (pc),
        .load_fault (misaligned),
        .ifex_valid (ifex_valid),
        .ifex_instr (ifex_instr),
        .ifex_pc    (ifex_pc),
        .ifex_pc4   (ifex_pc4),
        .ifex_fault (ifex_fault)
    );

endmodule

// File: tb/tb_tspp_fetch_stage.sv
// Directed bench for tspp_fetch_stage: vector table for the main flow,
// hand-written sequences for halt, misaligned redirect and PC wrap.
module tb_tspp_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        pc_en, npc_sel, if_ex_stall, if_ex_flush, halt, imem_busy;
    logic [31:0] brj_addr, imem_rdata;
    logic        imem_ren, iren, i_ram_busy, ifex_valid, ifex_fault;
    logic [31:0] imem_addr, ifex_instr, ifex_pc, ifex_pc4;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory model: data is a fixed scramble of the address.
    assign imem_rdata = mem(imem_addr);

    tspp_fetch_stage dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .pc_en       (pc_en),
        .npc_sel     (npc_sel),
        .if_ex_stall (if_ex_stall),
        .if_ex_flush (if_ex_flush),
        .halt        (halt),
        .brj_addr    (brj_addr),
        .imem_busy   (imem_busy),
        .imem_rdata  (imem_rdata),
        .imem_ren    (imem_ren),
        .imem_addr   (imem_addr),
        .iren        (iren),
        .i_ram_busy  (i_ram_busy),
        .ifex_valid  (ifex_valid),
        .ifex_instr  (ifex_instr),
        .ifex_pc     (ifex_pc),
        .ifex_pc4    (ifex_pc4),
        .ifex_fault  (ifex_fault)
    );

    typedef struct {
        logic        en, sel, st, fl, busy;
        logic [31:0] brj;
        logic        ren;
        logic [31:0] addr;
        logic        irb, valid;
        logic [31:0] instr, pc, pc4;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic en, sel, st, fl, busy,
                                input logic [31:0] brj,
                                input logic ren, input logic [31:0] addr,
                                input logic irb, valid,
                                input logic [31:0] instr, pc);
        vec_t v;
        v.en = en; v.sel = sel; v.st = st; v.fl = fl; v.busy = busy;
        v.brj = brj; v.ren = ren; v.addr = addr; v.irb = irb;
        v.valid = valid; v.instr = instr; v.pc = pc;
        v.pc4 = (pc == 32'h0) ? 32'h0 : pc + 32'd4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, sel, st, fl, hl, busy, input logic [31:0] brj);
        pc_en = en; npc_sel = sel; if_ex_stall = st; if_ex_flush = fl;
        halt = hl; imem_busy = busy; brj_addr = brj;
    endtask

    task automatic next_cycle;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // en sel st fl busy brj  | ren addr irb | valid instr pc
        vecs[0]  = mk(1,0,0,0,0,0,       1,32'h200,0, 0,NOP,0);
        vecs[1]  = mk(1,0,0,0,0,0,       1,32'h204,0, 1,mem(32'h200),32'h200);
        vecs[2]  = mk(1,0,0,0,0,0,       1,32'h208,0, 1,mem(32'h204),32'h204);
        vecs[3]  = mk(0,0,0,0,1,0,       1,32'h20C,1, 1,mem(32'h208),32'h208);
        vecs[4]  = mk(0,0,0,0,1,0,       1,32'h20C,1, 0,NOP,32'h208);
        vecs[5]  = mk(1,0,0,0,0,0,       1,32'h20C,0, 0,NOP,32'h208);
        vecs[6]  = mk(0,0,0,0,1,0,       1,32'h210,1, 1,mem(32'h20C),32'h20C);
        vecs[7]  = mk(1,1,0,0,1,32'h400, 1,32'h210,1, 0,NOP,32'h20C);
        vecs[8]  = mk(0,0,0,0,1,0,       1,32'h210,1, 0,NOP,32'h20C);
        vecs[9]  = mk(0,0,0,0,0,0,       1,32'h210,1, 0,NOP,32'h20C);
        vecs[10] = mk(1,0,0,0,0,0,       1,32'h400,0, 0,NOP,32'h20C);
        vecs[11] = mk(1,0,0,0,0,0,       1,32'h404,0, 1,mem(32'h400),32'h400);
        vecs[12] = mk(0,0,1,1,0,0,       1,32'h408,0, 1,mem(32'h404),32'h404);
        vecs[13] = mk(1,0,0,0,0,0,       1,32'h408,0, 0,NOP,32'h404);
        vecs[14] = mk(0,0,1,0,0,0,       1,32'h40C,0, 1,mem(32'h408),32'h408);
        vecs[15] = mk(0,0,0,0,0,0,       1,32'h40C,0, 1,mem(32'h408),32'h408);
        vecs[16] = mk(1,0,0,0,0,0,       1,32'h40C,0, 1,mem(32'h40C),32'h40C);
        vecs[17] = mk(0,0,0,0,0,0,       1,32'h410,0, 1,mem(32'h40C),32'h40C);

        // Reset with fetch enabled and memory idle.
        nRST = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        @(negedge CLK);
        chk("rst_valid", {31'b0, ifex_valid}, 32'h0);
        chk("rst_instr", ifex_instr, NOP);
        chk("rst_pc",    ifex_pc,    32'h0);
        chk("rst_pc4",   ifex_pc4,   32'h0);
        chk("rst_fault", {31'b0, ifex_fault}, 32'h0);
        chk("rst_addr",  imem_addr,  32'h200);
        next_cycle();
        next_cycle();
        nRST = 1'b1;

        // Main flow: sequential fetch, wait states, redirect squash, flush/stall.
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].en, vecs[i].sel, vecs[i].st, vecs[i].fl, 1'b0, vecs[i].busy, vecs[i].brj);
            @(negedge CLK);
            chk($sformatf("v%0d_ren", i),   {31'b0, imem_ren},   {31'b0, vecs[i].ren});
            chk($sformatf("v%0d_iren", i),  {31'b0, iren},       {31'b0, vecs[i].ren});
            chk($sformatf("v%0d_addr", i),  imem_addr,           vecs[i].addr);
            chk($sformatf("v%0d_irb", i),   {31'b0, i_ram_busy}, {31'b0, vecs[i].irb});
            chk($sformatf("v%0d_valid", i), {31'b0, ifex_valid}, {31'b0, vecs[i].valid});
            chk($sformatf("v%0d_instr", i), ifex_instr,          vecs[i].instr);
            chk($sformatf("v%0d_pc", i),    ifex_pc,             vecs[i].pc);
            chk($sformatf("v%0d_pc4", i),   ifex_pc4,            vecs[i].pc4);
            next_cycle();
        end

        // Halt while busy at 0x410: SQUASH until busy drops, then IDLE for good.
        drive(0, 0, 0, 0, 1, 1, 32'h0);
        @(negedge CLK);
        chk("h0_addr",  imem_addr, 32'h410);
        chk("h0_irb",   {31'b0, i_ram_busy}, 32'h1);
        chk("h0_valid", {31'b0, ifex_valid}, 32'h1);
        chk("h0_instr", ifex_instr, mem(32'h410));
        next_cycle();
        drive(0, 0, 0, 0, 0, 1, 32'h0);
        @(negedge CLK);
        chk("h1_ren",   {31'b0, imem_ren}, 32'h1);
        chk("h1_addr",  imem_addr, 32'h410);
        chk("h1_valid", {31'b0, ifex_valid}, 32'h0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        @(negedge CLK);
        chk("h2_ren",   {31'b0, imem_ren}, 32'h1);
        chk("h2_irb",   {31'b0, i_ram_busy}, 32'h1);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 0, 32'h0);
            @(negedge CLK);
            chk($sformatf("idle%0d_ren", k),   {31'b0, imem_ren},   32'h0);
            chk($sformatf("idle%0d_iren", k),  {31'b0, iren},       32'h0);
            chk($sformatf("idle%0d_irb", k),   {31'b0, i_ram_busy}, 32'h1);
            chk($sformatf("idle%0d_valid", k), {31'b0, ifex_valid}, 32'h0);
            next_cycle();
        end

        // Reset out of IDLE, then misaligned redirect and PC wrap.
        nRST = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 32'h402);
        @(negedge CLK);
        chk("rst2_pc",   ifex_pc,   32'h0);
        chk("rst2_addr", imem_addr, 32'h200);
        next_cycle();
        nRST = 1'b1;
        @(negedge CLK);
        chk("s0_ren",  {31'b0, imem_ren}, 32'h1);
        chk("s0_addr", imem_addr, 32'h200);
        next_cycle();
        drive(1, 1, 0, 0, 0, 0, 32'hFFFF_FFFC);
        @(negedge CLK);
        chk("s1_pc",   ifex_pc, 32'h200);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("s1_ren",  {31'b0, imem_ren}, 32'h0);
        chk("s1_addr", imem_addr, 32'h402);
`else
        chk("s1_ren",  {31'b0, imem_ren}, 32'h1);
        chk("s1_addr", imem_addr, 32'h400);
`endif
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        @(negedge CLK);
        chk("s2_addr",  imem_addr, 32'hFFFF_FFFC);
        chk("s2_valid", {31'b0, ifex_valid}, 32'h1);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("s2_fault", {31'b0, ifex_fault}, 32'h1);
        chk("s2_instr", ifex_instr, NOP);
        chk("s2_pc",    ifex_pc,    32'h402);
        chk("s2_pc4",   ifex_pc4,   32'h406);
`else
        chk("s2_fault", {31'b0, ifex_fault}, 32'h0);
        chk("s2_instr", ifex_instr, mem(32'h400));
        chk("s2_pc",    ifex_pc,    32'h400);
        chk("s2_pc4",   ifex_pc4,   32'h404);
`endif
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        @(negedge CLK);
        chk("s3_addr",  imem_addr, 32'h0);
        chk("s3_pc",    ifex_pc,   32'hFFFF_FFFC);
        chk("s3_pc4",   ifex_pc4,  32'h0);
        chk("s3_fault", {31'b0, ifex_fault}, 32'h0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tspp_fetch_stage.md
Name: tspp_fetch_stage

Overview:
- Fetch stage of the two-stage pipeline: owns the PC and issues instruction-memory reads.
- Absorbs memory wait states and squashes fetches made stale by a redirect.
- Drives the IF/EX pipeline latch consumed by execute.
- Takes pc_en, npc_sel, if_ex_stall and if_ex_flush from the hazard unit; reports i_ram_busy and iren back to it.

Parameters:
- RESET_PC, 32'h0000_0200, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- CLK  in  1  clock; all state on rising edge.
- nRST  in  1  asynchronous active-low reset.
- pc_en  in  1  hazard unit: PC may advance this cycle.
- npc_sel  in  1  hazard unit: 1 = next PC is brj_addr, 0 = PC+4.
- if_ex_stall  in  1  hazard unit: hold IF/EX latch.
- if_ex_flush  in  1  hazard unit: bubble IF/EX latch.
- halt  in  1  execute: stop fetching (sticky).
- brj_addr  in  32  execute: redirect target.
- imem_busy  in  1  memory: request not yet complete.
- imem_rdata  in  32  memory: instruction, valid when imem_ren & !imem_busy.
- imem_ren  out  1  memory read request.
- imem_addr  out  32  memory read address.
- iren  out  1  to hazard unit; equals imem_ren.
- i_ram_busy  out  1  to hazard unit; fetch not yet delivered.
- ifex_valid  out  1  latch holds a real instruction.
- ifex_instr  out  32  latched instruction.
- ifex_pc  out  32  PC of latched instruction.
- ifex_pc4  out  32  ifex_pc+4.
- ifex_fault  out  1  misaligned-fetch flag (see Optional Feature).

Behaviour:
- Reset values:
  - pc = RESET_PC; state = FETCH; halted_r = 0.
  - ifex_valid = 0, ifex_instr = NOP_INSTR, ifex_pc = 0, ifex_pc4 = 0, ifex_fault = 0.
  - Reset mid-transaction abandons the transaction; memory is reset by the same nRST.
- FSM states: FETCH, SQUASH, IDLE.
  - FETCH: imem_ren = 1, imem_addr = pc.
  - SQUASH: imem_ren = 1, imem_addr = squash_addr; returned data is discarded.
  - IDLE: imem_ren = 0, imem_addr = pc.
- Memory protocol: address and ren held stable while imem_busy = 1. A fetch completes in the cycle imem_ren = 1 and imem_busy = 0; minimum latency 0 wait states.
- i_ram_busy = imem_busy | (state == SQUASH) | (state == IDLE). The hazard unit never sees a completed fetch for discarded data.
- PC update when pc_en: pc <= npc_sel ? brj_addr : pc + 4, mod 2^32 (0xFFFF_FFFC + 4 = 0).
- Transitions:
  - FETCH -> SQUASH when (pc_en & npc_sel & imem_busy) or (halt & imem_busy); squash_addr <= pc (old value).
  - FETCH -> IDLE when halt & !imem_busy.
  - SQUASH -> FETCH when !imem_busy & !halted_r; SQUASH -> IDLE when !imem_busy & halted_r.
  - IDLE is terminal until reset.
- halt sets halted_r (sticky).
- IF/EX latch update, in priority order:
  1. if_ex_flush: valid = 0, instr = NOP_INSTR, fault = 0. Flush wins over a simultaneous stall.
  2. if_ex_stall: hold all fields.
  3. fetch complete in FETCH: valid = 1, instr = imem_rdata, pc = pc, pc4 = pc + 4.
  4. otherwise: valid = 0, instr = NOP_INSTR (bubble).
- A completion in SQUASH never loads the latch.
- Simultaneous stall and fetch completion: instruction is not latched. The hazard unit must hold pc_en low so the fetch repeats.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - In FETCH with pc[1:0] != 0: imem_ren = 0 and the fetch counts as complete immediately.
  - Latch loads valid = 1, instr = NOP_INSTR, fault = 1, pc = faulting pc.
  - Priority rules above still apply.
- Undefined: pc[1:0] forced to 2'b00 on every PC load; ifex_fault tied 0.

Decomposition:
- rv32i_types_pkg: word_t; new fetch_state_t enum {FETCH, SQUASH, IDLE}; constant RV32_NOP = 32'h0000_0013.
- Sub-module tspp_ifex_latch: holds the latch fields and the flush/stall/load priority.
- The FSM and PC stay in the top module.

Test Plan:
- Reset: release nRST with imem_busy = 0, pc_en = 1 -> imem_addr 0x200, 0x204, 0x208 on consecutive cycles; ifex_pc follows one cycle later, ifex_valid = 1.
- Wait states: imem_busy high 2 cycles at 0x204 -> imem_addr stable 3 cycles, i_ram_busy = 1 for 2 cycles, two bubbles, then ifex_instr = rdata.
- Redirect during busy: npc_sel = 1, pc_en = 1, brj_addr = 0x400 while busy at 0x208 -> SQUASH with addr 0x208 until busy drops; its data is discarded; next request is 0x400.
- Flush over stall: assert if_ex_stall and if_ex_flush together -> ifex_valid = 0, ifex_instr = 0x13; stall alone -> all latch fields unchanged.
- Halt: halt with busy = 1 -> SQUASH then IDLE; imem_ren = 0 thereafter; i_ram_busy = 1.
- With FETCH_MISALIGN_CHECK_EN: brj_addr = 0x402 -> imem_ren = 0, ifex_fault = 1, ifex_pc = 0x402.
- Without FETCH_MISALIGN_CHECK_EN: brj_addr = 0x402 -> fetch from 0x400, ifex_fault = 0.
